// File: rtl/ssd1306_spi_rx.sv
// SSD1306 4-wire serial receiver: byte assembly, command decode and GDDRAM write strobes.
// Optional macro SSD1306_RX_CS_EN enables oled_cs_n framing of the serial stream.
module ssd1306_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int COL_BITS    = 7,
    parameter int PAGE_BITS   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          oled_sclk,
    input  logic                          oled_sdin,
    input  logic                          oled_dc,
    input  logic                          oled_res,
    input  logic                          oled_cs_n,
    output logic                          cmd_valid,
    output logic [7:0]                    cmd_byte,
    output logic [7:0]                    cmd_p0,
    output logic [7:0]                    cmd_p1,
    output logic                          cmd_err,
    output logic                          gram_we,
    output logic [PAGE_BITS+COL_BITS-1:0] gram_addr,
    output logic [7:0]                    gram_wdata,
    output logic                          display_on,
    output logic                          invert,
    output logic                          entire_on,
    output logic [7:0]                    contrast,
    output logic                          charge_pump,
    output logic [1:0]                    mem_mode
);
    typedef enum logic [1:0] {IDLE = 2'd0, PARAM1 = 2'd1, PARAM2 = 2'd2} state_t;

    function automatic logic [1:0] n_params(input logic [7:0] op);
        case (op)
            8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: n_params = 2'd1;
            8'h21, 8'h22:                                                  n_params = 2'd2;
            default:                                                       n_params = 2'd0;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, sdin_sync_q, sdin_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d, res_sync_q, res_sync_d;
    logic sclk_s, sdin_s, dc_s, res_s, cs_s;

    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], oled_sclk};
    assign sdin_sync_d = {sdin_sync_q[SYNC_STAGES-2:0], oled_sdin};
    assign dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], oled_dc};
    assign res_sync_d  = {res_sync_q[SYNC_STAGES-2:0], oled_res};
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdin_s = sdin_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign res_s  = res_sync_q[SYNC_STAGES-1];

`ifdef SSD1306_RX_CS_EN
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    assign cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], oled_cs_n};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_sync_q <= '1;
        else        cs_sync_q <= cs_sync_d;
    end
    assign cs_s = cs_sync_q[SYNC_STAGES-1];
`else
    logic unused_cs_n;
    assign unused_cs_n = oled_cs_n;
    assign cs_s        = 1'b0;
`endif

    state_t state_q, state_d;
    logic sclk_prev_q, sclk_prev_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] op_q, op_d, p0_q, p0_d;
    logic cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d, gram_we_q, gram_we_d;
    logic [7:0] cmd_byte_q, cmd_byte_d, cmd_p0_q, cmd_p0_d, cmd_p1_q, cmd_p1_d;
    logic [7:0] gram_wdata_q, gram_wdata_d, contrast_q, contrast_d;
    logic [PAGE_BITS+COL_BITS-1:0] gram_addr_q, gram_addr_d;
    logic display_on_q, display_on_d, invert_q, invert_d, entire_on_q, entire_on_d;
    logic charge_pump_q, charge_pump_d;
    logic [1:0] mem_mode_q, mem_mode_d;
    logic [COL_BITS-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PAGE_BITS-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

    logic rise, byte_done, exec;
    logic [7:0] rx_byte, ex_op, ex_p0, ex_p1;

    assign rise      = sclk_s & ~sclk_prev_q & ~cs_s;
    assign byte_done = rise && (bitcnt_q == 3'd7);
    assign rx_byte   = {shift_q, sdin_s};
    assign sclk_prev_d = sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A data byte aborts any pending parameter collection.
    always_comb begin
        state_d = state_q;
        if (!res_s) begin
            state_d = IDLE;
        end else if (byte_done) begin
            case (state_q)
                IDLE:    if (!dc_s && n_params(rx_byte) != 2'd0) state_d = PARAM1;
                PARAM1:  if (dc_s || n_params(op_q) == 2'd1) state_d = IDLE;
                         else state_d = PARAM2;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d = shift_q;           bitcnt_d = bitcnt_q;
        op_d = op_q;                 p0_d = p0_q;
        cmd_valid_d = 1'b0;          cmd_err_d = 1'b0;          gram_we_d = 1'b0;
        cmd_byte_d = cmd_byte_q;     cmd_p0_d = cmd_p0_q;       cmd_p1_d = cmd_p1_q;
        gram_addr_d = gram_addr_q;   gram_wdata_d = gram_wdata_q;
        display_on_d = display_on_q; invert_d = invert_q;       entire_on_d = entire_on_q;
        contrast_d = contrast_q;     charge_pump_d = charge_pump_q; mem_mode_d = mem_mode_q;
        col_d = col_q;   col_start_d = col_start_q;   col_end_d = col_end_q;
        page_d = page_q; page_start_d = page_start_q; page_end_d = page_end_q;
        exec = 1'b0; ex_op = rx_byte; ex_p0 = 8'h00; ex_p1 = 8'h00;
        if (!res_s) begin
            shift_d = '0; bitcnt_d = '0; op_d = '0; p0_d = '0;
            cmd_byte_d = '0; cmd_p0_d = '0; cmd_p1_d = '0; gram_addr_d = '0; gram_wdata_d = '0;
            display_on_d = 1'b0; invert_d = 1'b0; entire_on_d = 1'b0;
            contrast_d = 8'h7F; charge_pump_d = 1'b0; mem_mode_d = 2'd2;
            col_d = '0; col_start_d = '0; col_end_d = '1;
            page_d = '0; page_start_d = '0; page_end_d = '1;
        end else begin
            if (rise) begin
                shift_d  = {shift_q[5:0], sdin_s};
                bitcnt_d = bitcnt_q + 3'd1;
            end
            if (cs_s) bitcnt_d = '0;
            if (byte_done && dc_s) begin
                gram_we_d    = 1'b1;
                gram_addr_d  = {page_q, col_q};
                gram_wdata_d = rx_byte;
                cmd_err_d    = (state_q != IDLE);
                case (mem_mode_q)
                    2'd0: if (col_q == col_end_q) begin
                              col_d  = col_start_q;
                              page_d = (page_q == page_end_q) ? page_start_q : page_q + PAGE_BITS'(1);
                          end else col_d = col_q + COL_BITS'(1);
                    2'd1: if (page_q == page_end_q) begin
                              page_d = page_start_q;
                              col_d  = (col_q == col_end_q) ? col_start_q : col_q + COL_BITS'(1);
                          end else page_d = page_q + PAGE_BITS'(1);
                    default: col_d = col_q + COL_BITS'(1);
                endcase
            end else if (byte_done) begin
                case (state_q)
                    IDLE:    if (n_params(rx_byte) == 2'd0) exec = 1'b1;
                             else op_d = rx_byte;
                    PARAM1:  if (n_params(op_q) == 2'd1) begin
                                 exec = 1'b1; ex_op = op_q; ex_p0 = rx_byte;
                             end else p0_d = rx_byte;
                    default: begin exec = 1'b1; ex_op = op_q; ex_p0 = p0_q; ex_p1 = rx_byte; end
                endcase
            end
            if (exec) begin
                cmd_valid_d = 1'b1; cmd_byte_d = ex_op; cmd_p0_d = ex_p0; cmd_p1_d = ex_p1;
                case (ex_op)
                    8'hAE, 8'hAF: display_on_d = ex_op[0];
                    8'hA6, 8'hA7: invert_d     = ex_op[0];
                    8'hA4, 8'hA5: entire_on_d  = ex_op[0];
                    8'h81:        contrast_d   = ex_p0;
                    8'h20:        if (ex_p0[1:0] != 2'd3) mem_mode_d = ex_p0[1:0];
                    8'h8D:        charge_pump_d = ex_p0[2];
                    8'h21: begin
                        col_start_d = ex_p0[COL_BITS-1:0]; col_end_d = ex_p1[COL_BITS-1:0];
                        col_d       = ex_p0[COL_BITS-1:0];
                    end
                    8'h22: begin
                        page_start_d = ex_p0[PAGE_BITS-1:0]; page_end_d = ex_p1[PAGE_BITS-1:0];
                        page_d       = ex_p0[PAGE_BITS-1:0];
                    end
                    default: begin
                        if (ex_op[7:4] == 4'h0)         col_d[3:0] = ex_op[3:0];
                        else if (ex_op[7:3] == 5'h02)   col_d[COL_BITS-1:4] = ex_op[COL_BITS-5:0];
                        else if (ex_op[7:3] == 5'h16)   page_d = ex_op[PAGE_BITS-1:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0; sdin_sync_q <= '0; dc_sync_q <= '0; res_sync_q <= '0;
            sclk_prev_q <= 1'b0; shift_q <= '0; bitcnt_q <= '0; op_q <= '0; p0_q <= '0;
            cmd_valid_q <= 1'b0; cmd_err_q <= 1'b0; gram_we_q <= 1'b0;
            cmd_byte_q <= '0; cmd_p0_q <= '0; cmd_p1_q <= '0; gram_addr_q <= '0; gram_wdata_q <= '0;
            display_on_q <= 1'b0; invert_q <= 1'b0; entire_on_q <= 1'b0;
            contrast_q <= 8'h7F; charge_pump_q <= 1'b0; mem_mode_q <= 2'd2;
            col_q <= '0; col_start_q <= '0; col_end_q <= '1;
            page_q <= '0; page_start_q <= '0; page_end_q <= '1;
        end else begin
            sclk_sync_q <= sclk_sync_d; sdin_sync_q <= sdin_sync_d;
            dc_sync_q <= dc_sync_d; res_sync_q <= res_sync_d;
            sclk_prev_q <= sclk_prev_d; shift_q <= shift_d; bitcnt_q <= bitcnt_d;
            op_q <= op_d; p0_q <= p0_d;
            cmd_valid_q <= cmd_valid_d; cmd_err_q <= cmd_err_d; gram_we_q <= gram_we_d;
            cmd_byte_q <= cmd_byte_d; cmd_p0_q <= cmd_p0_d; cmd_p1_q <= cmd_p1_d;
            gram_addr_q <= gram_addr_d; gram_wdata_q <= gram_wdata_d;
            display_on_q <= display_on_d; invert_q <= invert_d; entire_on_q <= entire_on_d;
            contrast_q <= contrast_d; charge_pump_q <= charge_pump_d; mem_mode_q <= mem_mode_d;
            col_q <= col_d; col_start_q <= col_start_d; col_end_q <= col_end_d;
            page_q <= page_d; page_start_q <= page_start_d; page_end_q <= page_end_d;
        end
    end

    assign cmd_valid = cmd_valid_q;   assign cmd_err = cmd_err_q;     assign gram_we = gram_we_q;
    assign cmd_byte = cmd_byte_q;     assign cmd_p0 = cmd_p0_q;       assign cmd_p1 = cmd_p1_q;
    assign gram_addr = gram_addr_q;   assign gram_wdata = gram_wdata_q;
    assign display_on = display_on_q; assign invert = invert_q;       assign entire_on = entire_on_q;
    assign contrast = contrast_q;     assign charge_pump = charge_pump_q; assign mem_mode = mem_mode_q;
endmodule

// File: doc/ssd1306_spi_rx.md
Name: ssd1306_spi_rx

Overview:
- Receive-side model of the SSD1306 4-wire serial interface. It is the display end of the link driven by our OLED configuration sequencer and SPI master.
- Oversamples the pad signals oled_sclk, oled_sdin, oled_dc and oled_res, assembles bytes, and decodes command and parameter sequences.
- Converts data bytes into GDDRAM write strobes with SSD1306 address auto-increment.
- Used as an on-chip display emulator and as the self-checking receiver in sequencer benches.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each pad input, minimum 2.
- COL_BITS, 7: column pointer width (128 columns).
- PAGE_BITS, 3: page pointer width (8 pages).

Ports:
- clk  in  1  system clock; must be at least 4x the oled_sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- oled_sclk  in  1  serial clock, SPI mode 0, MSB first.
- oled_sdin  in  1  serial data.
- oled_dc  in  1  0 = command/parameter byte, 1 = GDDRAM data byte.
- oled_res  in  1  display RES#, active low.
- oled_cs_n  in  1  chip select, active low (used only with the optional feature).
- cmd_valid  out  1  one-cycle strobe when a complete command has executed.
- cmd_byte  out  8  opcode of the last executed command.
- cmd_p0, cmd_p1  out  8 each  first and second parameter of that command (0 if absent).
- cmd_err  out  1  one-cycle strobe when a command is aborted by a data byte.
- gram_we  out  1  one-cycle GDDRAM write strobe.
- gram_addr  out  PAGE_BITS+COL_BITS  write address, {page, col}.
- gram_wdata  out  8  write data.
- display_on  out  1  state set by 0xAE / 0xAF.
- invert  out  1  state set by 0xA6 / 0xA7.
- entire_on  out  1  state set by 0xA4 / 0xA5.
- contrast  out  8  value set by 0x81.
- charge_pump  out  1  bit 2 of the 0x8D parameter.
- mem_mode  out  2  addressing mode: 0 = horizontal, 1 = vertical, 2 = page.

Behaviour:
- Reset values (rst_n low asynchronously, or synchronised oled_res low synchronously):
  - all strobes 0; cmd_byte, cmd_p0, cmd_p1, gram_addr, gram_wdata 0.
  - display_on 0, invert 0, entire_on 0, contrast 0x7F, charge_pump 0, mem_mode 2.
  - col 0, page 0; col range 0..127, page range 0..7.
  - bit count 0; FSM in IDLE.
- Input synchronisation and sampling:
  - Every pad input passes through SYNC_STAGES flops.
  - A sclk rise is synchronised sclk = 1 with its previous value 0.
  - On each rise, synchronised sdin is shifted in MSB first and the 3-bit bit count increments.
  - On the 8th rise: byte complete, dc is latched from synchronised dc, and the bit count wraps to 0.
- Latency: all outputs for a byte update exactly 1 clk after the clk in which the 8th rise is detected.
- Command FSM states: IDLE, PARAM1, PARAM2.
  - Command byte in IDLE: look up the parameter count N.
    - N=0: execute immediately.
    - N>0: store the opcode and go to PARAM1.
  - PARAM1: a dc=0 byte is stored as p0. If N=1, execute and go to IDLE; otherwise go to PARAM2.
  - PARAM2: a dc=0 byte is stored as p1; execute and go to IDLE.
  - A dc=1 byte arriving in PARAM1 or PARAM2:
    - pulse cmd_err and return to IDLE with no register change;
    - the same byte is still processed as data, with gram_we in the same cycle as cmd_err.
- Execute: pulse cmd_valid for 1 clk; update cmd_byte, cmd_p0 and cmd_p1 (unused parameters = 0).
- Commands with N=0:
  - 0xAE / 0xAF display_on; 0xA6 / 0xA7 invert; 0xA4 / 0xA5 entire_on.
  - 0x00–0x0F set col[3:0]; 0x10–0x17 set col[6:4]; 0xB0–0xB7 set page.
  - Any other opcode (including 0x40–0x7F): cmd_valid only.
- Commands with N=1:
  - 0x81 sets contrast = p0.
  - 0x20 sets mem_mode = p0[1:0]; the value 3 is ignored but still reported via cmd_valid.
  - 0x8D sets charge_pump = p0[2].
  - 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: cmd_valid only.
- Commands with N=2:
  - 0x21 sets col range to p0[6:0]..p1[6:0] and col = start.
  - 0x22 sets page range to p0[2:0]..p1[2:0] and page = start.
- Data byte: gram_we=1, gram_addr={page, col}, gram_wdata=byte. Pointers then advance by mem_mode:
  - Page mode: col+1, wrapping 127→0; page unchanged.
  - Horizontal: if col==col_end, col=col_start and page advances (page_end→page_start, else +1); otherwise col+1.
  - Vertical: same as horizontal with the roles of page and col swapped.
- oled_res asserted mid-byte: the partial byte is discarded and registers return to reset values. The next byte starts at bit 0 after oled_res rises.

Optional Feature:
- Macro: SSD1306_RX_CS_EN.
- Defined:
  - oled_cs_n passes through the synchroniser.
  - While it is high, sclk edges are ignored and the bit count is held at 0; a partial byte is discarded.
  - The FSM state is kept across a cs_n toggle.
- Undefined: oled_cs_n is unused; the receiver behaves as if it were tied low, and framing relies on oled_res only.

Test Plan:
- Send cmd 0xAF (dc=0) → 1 clk after the 8th rise: cmd_valid=1, cmd_byte=0xAF, display_on=1, cmd_p0=cmd_p1=0.
- Send 0x81 then 0x3C (dc=0) → a single cmd_valid after the second byte, with cmd_p0=0x3C and contrast=0x3C. No cmd_valid after the first byte.
- Page mode: send 0xB2, 0x0F, 0x17, then data 0xAA, 0x55 (dc=1).
  - Expect gram_addr 0x17F with data 0xAA, then 0x100 with data 0x55 (col wrapped 127→0, page stays 2).
- Horizontal mode: send 0x20, 0x00; 0x21, 0x7E, 0x7F; 0x22, 0x06, 0x07; then 5 data bytes.
  - Expect addresses 0x37E, 0x37F, 0x3FE, 0x3FF, 0x37E.
- Send 0x81, then data 0x12 (dc=1) → cmd_err and gram_we in the same cycle, contrast still 0x7F, FSM back in IDLE.
- Pull oled_res low after 4 bits of a byte, then release and send 0xA7 → contrast=0x7F and invert=1 (no bit misalignment). With SSD1306_RX_CS_EN defined, a cs_n pulse mid-byte gives the same realignment.
